alu_seq: RTL

- Parametrised, registered successor of the combinational 16-bit ALU.
- Keeps opcodes 0x0–0xA and adds iterative multiply, multiply-high, unsigned divide and unsigned remainder.
- Sits between decode and writeback.
- Uses a valid/ready handshake on input and output, with one operation in flight at a time.

---
 rtl/alu_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and iterative multiply/divide
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_wordA,
  input  logic [WIDTH-1:0] i_wordB,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_flag_zero,
  output logic             o_flag_sign,
  output logic             o_flag_overflow,
  output logic             o_flag_carry,
  output logic             o_flag_divzero
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;
  state_t state;
  logic [3:0] op;
  logic [WIDTH-1:0] a, b, alu_res, rem_next, it_res;
  logic [SHW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0] sum, dif, mul_sum, rw;
  logic alu_ovf, alu_cry, iter, is_div, ge;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    case (op)
      4'h0: alu_res = sum[WIDTH-1:0];
      4'h1: alu_res = dif[WIDTH-1:0];
      4'h2: alu_res = a & b;
      4'h3: alu_res = a | b;
      4'h4: alu_res = a ^ b;
      4'h5: alu_res = a << b[SHW-1:0];
      4'h6: alu_res = a >> b[SHW-1:0];
      4'h7: alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      4'h8: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'h9: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'hA: alu_res = {{(WIDTH-1){1'b0}}, ^a};
      4'hD: alu_res = '1;
      4'hE: alu_res = a;
      default: alu_res = '0;
    endcase
    alu_ovf = op == 4'h0 ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
              op == 4'h1 ? (a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    alu_cry = op == 4'h0 ? sum[WIDTH] : op == 4'h1 ? dif[WIDTH] : 1'b0;
    iter = op >= 4'hB && op <= 4'hE;
    is_div = op == 4'hD || op == 4'hE;
    // multiply: add A into the high half when the multiplier LSB is set, then shift right
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
    // divide: shift the next dividend bit into the remainder and subtract B if it fits
    rw = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge = rw >= {1'b0, b};
    rem_next = ge ? WIDTH'(rw - {1'b0, b}) : rw[WIDTH-1:0];
    acc_next = is_div ? {rem_next, acc[WIDTH-2:0], ge} : {mul_sum, acc[WIDTH-1:1]};
    it_res = (op == 4'hB || op == 4'hD) ? acc_next[WIDTH-1:0] : acc_next[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      op <= '0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      acc <= '0;
      o_result <= '0;
      o_flag_zero <= 1'b0;
      o_flag_sign <= 1'b0;
      o_flag_overflow <= 1'b0;
      o_flag_carry <= 1'b0;
      o_flag_divzero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (i_valid) begin
          op <= i_opcode;
          a <= i_wordA;
          b <= i_wordB;
          state <= LOAD;
        end
        LOAD: if (iter && !(is_div && b == '0)) begin
          acc <= {{WIDTH{1'b0}}, is_div ? a : b};
          cnt <= '0;
          state <= BUSY;
        end else begin
          o_result <= alu_res;
          o_flag_zero <= alu_res == '0;
          o_flag_sign <= alu_res[WIDTH-1];
          o_flag_overflow <= alu_ovf;
          o_flag_carry <= alu_cry;
          o_flag_divzero <= is_div;
          state <= DONE;
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) begin
            o_result <= it_res;
            o_flag_zero <= it_res == '0;
            o_flag_sign <= it_res[WIDTH-1];
            o_flag_overflow <= 1'b0;
            o_flag_carry <= 1'b0;
            o_flag_divzero <= 1'b0;
            state <= DONE;
          end
        end
        DONE: if (i_ready) state <= IDLE;
      endcase
    end
  end
endmodule
